// File: rtl/spike_packet_encoder.sv
// spike_packet_encoder
// Captures one spike vector per timestep and serialises every set bit into a
// {CORE_ID, neuron index} packet on a valid/ready stream, in ascending index
// order. A one-cycle frame-done pulse reports the number of spikes sent.
module spike_packet_encoder #(
  parameter int NUM_NEURONS = 256,
  parameter int ID_W        = 8,
  parameter int CORE_ID_W   = 8,
  parameter int CORE_ID     = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_NEURONS-1:0]    spike_vec_i,
  input  logic                      spike_valid_i,
  output logic [CORE_ID_W+ID_W-1:0] pkt_data_o,
  output logic                      pkt_valid_o,
  input  logic                      pkt_ready_i,
  output logic                      frame_done_o,
  output logic [ID_W:0]             spike_count_o,
  output logic                      busy_o,
  output logic                      overflow_o,
  input  logic                      clear_ovf_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ID_W-1:0]      LAST_IDX    = ID_W'(NUM_NEURONS - 1);
  localparam logic [CORE_ID_W-1:0] CORE_ID_VAL = CORE_ID_W'(CORE_ID);

  state_t                      state_reg, state_next;
  logic [NUM_NEURONS-1:0]      shadow_reg, shadow_next;
  logic [ID_W-1:0]             idx_reg, idx_next;
  logic [ID_W:0]               cnt_reg, cnt_next;
  logic [CORE_ID_W+ID_W-1:0]   pkt_data_reg, pkt_data_next;
  logic                        pkt_valid_reg, pkt_valid_next;
  logic                        frame_done_reg, frame_done_next;
  logic [ID_W:0]               spike_count_reg, spike_count_next;
  logic                        overflow_reg, overflow_next;

  // The output slot is free when empty or when its packet is taken this edge.
  logic advance;
  assign advance = !pkt_valid_reg || pkt_ready_i;

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      shadow_reg      <= '0;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      pkt_data_reg    <= '0;
      pkt_valid_reg   <= 1'b0;
      frame_done_reg  <= 1'b0;
      spike_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shadow_reg      <= shadow_next;
      idx_reg         <= idx_next;
      cnt_reg         <= cnt_next;
      pkt_data_reg    <= pkt_data_next;
      pkt_valid_reg   <= pkt_valid_next;
      frame_done_reg  <= frame_done_next;
      spike_count_reg <= spike_count_next;
      overflow_reg    <= overflow_next;
    end
  end

  // Next-state and datapath logic: capture in IDLE, one index per advance in
  // SCAN, and report the count once the last packet has been taken.
  always_comb begin
    state_next       = state_reg;
    shadow_next      = shadow_reg;
    idx_next         = idx_reg;
    cnt_next         = cnt_reg;
    pkt_data_next    = pkt_data_reg;
    pkt_valid_next   = pkt_valid_reg;
    frame_done_next  = 1'b0;
    spike_count_next = spike_count_reg;

    // A strobe arriving while a frame is in progress is dropped and flagged;
    // the set takes priority over a simultaneous clear.
    overflow_next = clear_ovf_i ? 1'b0 : overflow_reg;
    if (spike_valid_i && (state_reg != IDLE)) begin
      overflow_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (spike_valid_i) begin
          shadow_next = spike_vec_i;
          idx_next    = '0;
          cnt_next    = '0;
          state_next  = SCAN;
        end
      end
      SCAN: begin
        if (advance) begin
          if (shadow_reg[idx_reg]) begin
            pkt_data_next  = {CORE_ID_VAL, idx_reg};
            pkt_valid_next = 1'b1;
            cnt_next       = cnt_reg + (ID_W+1)'(1);
          end else begin
            // Any packet still valid here was accepted on this edge.
            pkt_valid_next = 1'b0;
          end
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next = idx_reg + ID_W'(1);
          end
        end
      end
      DONE: begin
        if (advance) begin
          pkt_valid_next   = 1'b0;
          frame_done_next  = 1'b1;
          spike_count_next = cnt_reg;
          state_next       = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pkt_data_o    = pkt_data_reg;
  assign pkt_valid_o   = pkt_valid_reg;
  assign frame_done_o  = frame_done_reg;
  assign spike_count_o = spike_count_reg;
  assign busy_o        = (state_reg != IDLE);
  assign overflow_o    = overflow_reg;

endmodule

// File: tb/tb_spike_packet_encoder.sv
// Directed testbench for spike_packet_encoder with 256 neurons, CORE_ID 0.
module tb_spike_packet_encoder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] spike_vec;
  logic         spike_valid;
  logic [15:0]  pkt_data;
  logic         pkt_valid;
  logic         pkt_ready;
  logic         frame_done;
  logic [8:0]   spike_count;
  logic         busy;
  logic         overflow;
  logic         clear_ovf;

  int errors = 0;
  int checks = 0;

  // Per-frame capture filled by run_frame
  logic [15:0] got_data[$];
  int          got_cyc[$];
  int          done_cyc;

  spike_packet_encoder #(
    .NUM_NEURONS(256),
    .ID_W(8),
    .CORE_ID_W(8),
    .CORE_ID(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .spike_vec_i(spike_vec),
    .spike_valid_i(spike_valid),
    .pkt_data_o(pkt_data),
    .pkt_valid_o(pkt_valid),
    .pkt_ready_i(pkt_ready),
    .frame_done_o(frame_done),
    .spike_count_o(spike_count),
    .busy_o(busy),
    .overflow_o(overflow),
    .clear_ovf_i(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe vec in the current cycle (edge E0 is the next one) and then watch
  // cycles 1..budget after E0. Cycle k is the cycle after edge E0+k.
  // mode 0: ready always 1; mode 1: ready=1 on odd k only.
  // inj>0: a second strobe is driven during cycle inj (should be dropped).
  task automatic run_frame(input logic [255:0] vec, input int mode,
                           input int inj, input int budget);
    logic [15:0] prev_data;
    logic        prev_stall;
    got_data.delete();
    got_cyc.delete();
    done_cyc    = -1;
    prev_stall  = 1'b0;
    prev_data   = '0;
    spike_vec   = vec;
    spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    for (int k = 1; k <= budget && done_cyc < 0; k++) begin
      tick();
      spike_valid = 1'b0;
      if (prev_stall) begin
        checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                   k, pkt_valid, pkt_data, prev_data);
        end
      end
      if (frame_done === 1'b1) done_cyc = k;
      pkt_ready  = (mode == 0) ? 1'b1 : ((k % 2) == 1);
      prev_stall = pkt_valid && !pkt_ready;
      prev_data  = pkt_data;
      if (pkt_valid === 1'b1 && pkt_ready) begin
        got_data.push_back(pkt_data);
        got_cyc.push_back(k);
      end
      if (k == inj) begin
        spike_vec   = ~vec;
        spike_valid = 1'b1;
      end
    end
    spike_valid = 1'b0;
    pkt_ready   = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; spike_vec = '0; spike_valid = 1'b0;
    pkt_ready = 1'b1; clear_ovf = 1'b0;
    tick(); tick();
    checks++;
    if ({pkt_valid, pkt_data, frame_done, spike_count, busy, overflow} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h fd=%b c=%h b=%b o=%b want all 0",
               pkt_valid, pkt_data, frame_done, spike_count, busy, overflow);
    end
    #2 reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got busy=%b want 0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_sparse();
    logic [255:0] v;
    v = '0; v[0] = 1'b1; v[5] = 1'b1; v[255] = 1'b1;
    run_frame(v, 0, -1, 400);
    checks++;
    if (got_data.size() !== 3) begin
      errors++; $display("FAIL t1_npkts got=%0d want=3", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 16'h0000 || got_data[1] !== 16'h0005 || got_data[2] !== 16'h00FF) begin
        errors++; $display("FAIL t1_data got=%h,%h,%h want=0000,0005,00ff",
                           got_data[0], got_data[1], got_data[2]);
      end
      checks++;
      if (got_cyc[0] != 1 || got_cyc[1] != 6 || got_cyc[2] != 256) begin
        errors++; $display("FAIL t1_latency got=%0d,%0d,%0d want=1,6,256",
                           got_cyc[0], got_cyc[1], got_cyc[2]);
      end
    end
    checks++;
    if (done_cyc != 257) begin
      errors++; $display("FAIL t1_done_cyc got=%0d want=257", done_cyc);
    end
    checks++;
    if (spike_count !== 9'd3) begin
      errors++; $display("FAIL t1_count got=%0d want=3", spike_count);
    end
    $display("test_sparse pkts=%0d done=%0d count=%0d", got_data.size(), done_cyc, spike_count);
  endtask

  task automatic test_zero();
    run_frame('0, 0, -1, 400);
    checks++;
    if (got_data.size() !== 0) begin
      errors++; $display("FAIL t2_npkts got=%0d want=0", got_data.size());
    end
    checks++;
    if (done_cyc != 257) begin
      errors++; $display("FAIL t2_done_cyc got=%0d want=257", done_cyc);
    end
    checks++;
    if (spike_count !== 9'd0) begin
      errors++; $display("FAIL t2_count got=%0d want=0", spike_count);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL t2_done_pulse got=%b want=0", frame_done);
    end
    $display("test_zero done=%0d count=%0d", done_cyc, spike_count);
  endtask

  task automatic test_all_ones();
    int bad;
    run_frame({256{1'b1}}, 1, -1, 1000);
    checks++;
    if (got_data.size() !== 256) begin
      errors++; $display("FAIL t3_npkts got=%0d want=256", got_data.size());
    end
    bad = -1;
    for (int i = 0; i < got_data.size(); i++) begin
      if (bad < 0 && got_data[i] !== 16'(i)) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL t3_order at=%0d got=%h want=%h", bad, got_data[bad], 16'(bad));
    end
    checks++;
    if (done_cyc < 0) begin
      errors++; $display("FAIL t3_done got=timeout want=frame_done");
    end
    checks++;
    if (spike_count !== 9'h100) begin
      errors++; $display("FAIL t3_count got=%h want=100", spike_count);
    end
    $display("test_all_ones pkts=%0d count=%h", got_data.size(), spike_count);
  endtask

  task automatic test_stall();
    int bad;
    int k;
    logic [255:0] v;
    v = '0; v[3] = 1'b1;
    pkt_ready = 1'b0;
    spike_vec = v; spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c >= 4 && (pkt_valid !== 1'b1 || pkt_data !== 16'h0003 ||
                     frame_done !== 1'b0 || busy !== 1'b1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL t4_hold got bad_cycles=%0d want=0 (data=%h)", bad, pkt_data);
    end
    pkt_ready = 1'b1;
    k = 24;
    while (frame_done !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    checks++;
    if (k != 277) begin
      errors++; $display("FAIL t4_done_cyc got=%0d want=277", k);
    end
    checks++;
    if (spike_count !== 9'd1) begin
      errors++; $display("FAIL t4_count got=%0d want=1", spike_count);
    end
    $display("test_stall done=%0d count=%0d", k, spike_count);
  endtask

  task automatic test_overflow();
    logic [255:0] v;
    int k;
    v = '0; v[10] = 1'b1;
    run_frame(v, 0, 5, 400);
    checks++;
    if (got_data.size() !== 1 || got_data[0] !== 16'h000A || got_cyc[0] != 11) begin
      errors++; $display("FAIL t5_frame got n=%0d data=%h cyc=%0d want n=1 data=000a cyc=11",
                         got_data.size(), got_data[0], got_cyc[0]);
    end
    checks++;
    if (done_cyc != 257 || spike_count !== 9'd1) begin
      errors++; $display("FAIL t5_done got cyc=%0d count=%0d want cyc=257 count=1",
                         done_cyc, spike_count);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL t5_ovf_set got=%b want=1", overflow);
    end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL t5_ovf_clear got=%b want=0", overflow);
    end
    // Set and clear together while busy
    spike_vec = '0; spike_valid = 1'b1;
    tick();
    spike_valid = 1'b1; clear_ovf = 1'b1;
    tick();
    spike_valid = 1'b0; clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL t5_set_wins got=%b want=1", overflow);
    end
    k = 0;
    while (frame_done !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    checks++;
    if (overflow !== 1'b1 || frame_done !== 1'b1) begin
      errors++; $display("FAIL t5_sticky got ovf=%b done=%b want 1,1", overflow, frame_done);
    end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    $display("test_overflow ovf=%b", overflow);
  endtask

  task automatic test_back_to_back();
    logic [255:0] v;
    run_frame('0, 0, -1, 400);
    v = '0; v[42] = 1'b1;
    // frame_done is high in this cycle: the new strobe must be accepted
    run_frame(v, 0, -1, 400);
    checks++;
    if (got_data.size() !== 1 || got_data[0] !== 16'h002A || got_cyc[0] != 43) begin
      errors++; $display("FAIL b2b_frame got n=%0d data=%h cyc=%0d want n=1 data=002a cyc=43",
                         got_data.size(), got_data[0], got_cyc[0]);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_ovf got=%b want=0", overflow);
    end
    $display("test_back_to_back pkts=%0d count=%0d", got_data.size(), spike_count);
  endtask

  task automatic test_reset_mid();
    logic [255:0] v;
    run_frame({256{1'b1}}, 0, -1, 10);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({pkt_valid, pkt_data, frame_done, spike_count, busy, overflow} !== 29'd0) begin
      errors++;
      $display("FAIL t6_reset_outputs got v=%b d=%h fd=%b c=%h b=%b o=%b want all 0",
               pkt_valid, pkt_data, frame_done, spike_count, busy, overflow);
    end
    tick();
    reset_n = 1'b1;
    tick();
    v = '0; v[7] = 1'b1;
    run_frame(v, 0, -1, 400);
    checks++;
    if (got_data.size() !== 1 || got_data[0] !== 16'h0007 || got_cyc[0] != 8) begin
      errors++; $display("FAIL t6_frame got n=%0d data=%h cyc=%0d want n=1 data=0007 cyc=8",
                         got_data.size(), got_data[0], got_cyc[0]);
    end
    checks++;
    if (done_cyc != 257 || spike_count !== 9'd1) begin
      errors++; $display("FAIL t6_done got cyc=%0d count=%0d want cyc=257 count=1",
                         done_cyc, spike_count);
    end
    $display("test_reset_mid pkts=%0d count=%0d", got_data.size(), spike_count);
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_zero();
    test_all_ones();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
